// File: rtl/uart_cmd_decoder.sv
// Turns a UART character stream of "<op><hex digits><CR|LF>" into 34-bit Wishbone command words.
// Optional echo path: define UART_DEC_ECHO_EN to echo every accepted byte back toward the transmitter.
module uart_cmd_decoder #(
   parameter int TIMEOUT = 1000000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_rx_stb,
   input  logic [7:0]  i_rx_char,
   input  logic        i_cmd_busy,
   output logic        o_cmd_stb,
   output logic [33:0] o_cmd_word,
   output logic        o_err,
   output logic        o_echo_stb,
   output logic [7:0]  o_echo_char
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      ISSUE,
      DISCARD
   } state_t;

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ADDR = 2'b10;

   localparam bit TO_EN = (TIMEOUT > 0);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [31:0] value_q, value_d;
   logic [3:0] digit_cnt_q, digit_cnt_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic cmd_stb_q, cmd_stb_d;
   logic [33:0] cmd_word_q, cmd_word_d;
   logic err_q, err_d;

   logic is_term;
   logic is_hex;
   logic [3:0] hex_nib;
   logic is_op;
   logic [1:0] op_kind;
   logic waiting;
   logic timed_out;

   // Character classification: terminator, hex digit value and case-insensitive opcode.
   always_comb begin
      is_term = (i_rx_char == 8'h0D) || (i_rx_char == 8'h0A);
      is_hex = 1'b0;
      hex_nib = 4'h0;
      if (i_rx_char >= 8'h30 && i_rx_char <= 8'h39) begin
         is_hex = 1'b1;
         hex_nib = i_rx_char[3:0];
      end else if ((i_rx_char >= 8'h41 && i_rx_char <= 8'h46) ||
                   (i_rx_char >= 8'h61 && i_rx_char <= 8'h66)) begin
         is_hex = 1'b1;
         hex_nib = i_rx_char[3:0] + 4'd9;
      end
      is_op = 1'b0;
      op_kind = OP_READ;
      case (i_rx_char)
         8'h41, 8'h61: begin
            is_op = 1'b1;
            op_kind = OP_ADDR;
         end
         8'h57, 8'h77: begin
            is_op = 1'b1;
            op_kind = OP_WRITE;
         end
         8'h52, 8'h72: begin
            is_op = 1'b1;
            op_kind = OP_READ;
         end
         default: begin
            is_op = 1'b0;
            op_kind = OP_READ;
         end
      endcase
   end

   // Idle timer only runs while a command is partially received; a fresh char always wins over expiry.
   always_comb begin
      waiting = (state_q == COLLECT) || (state_q == DISCARD);
      idle_cnt_d = '0;
      if (TO_EN && waiting && !i_rx_stb) begin
         idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
      timed_out = TO_EN && waiting && !i_rx_stb && (idle_cnt_q == TO_LAST);
   end

   always_comb begin
      state_d = state_q;
      op_d = op_q;
      value_d = value_q;
      digit_cnt_d = digit_cnt_q;
      cmd_stb_d = cmd_stb_q;
      cmd_word_d = cmd_word_q;
      err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_rx_stb) begin
               if (is_op) begin
                  state_d = COLLECT;
                  op_d = op_kind;
                  value_d = 32'h0;
                  digit_cnt_d = 4'd0;
               end else if (!is_term) begin
                  err_d = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (i_rx_stb) begin
               if (is_term) begin
                  if (op_q != OP_READ && digit_cnt_q == 4'd0) begin
                     err_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = ISSUE;
                     cmd_stb_d = 1'b1;
                     cmd_word_d = {op_q, value_q};
                  end
               end else if (is_hex && op_q != OP_READ && digit_cnt_q != 4'd8) begin
                  value_d = {value_q[27:0], hex_nib};
                  digit_cnt_d = digit_cnt_q + 4'd1;
               end else begin
                  err_d = 1'b1;
                  state_d = DISCARD;
               end
            end else if (timed_out) begin
               err_d = 1'b1;
               state_d = IDLE;
            end
         end
         ISSUE: begin
            // Any char here is dropped, including one arriving on the handshake cycle itself.
            if (i_rx_stb) begin
               err_d = 1'b1;
            end
            if (!i_cmd_busy) begin
               cmd_stb_d = 1'b0;
               state_d = IDLE;
            end
         end
         DISCARD: begin
            if (i_rx_stb) begin
               if (is_term) begin
                  state_d = IDLE;
               end
            end else if (timed_out) begin
               err_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         op_q <= OP_READ;
         value_q <= 32'h0;
         digit_cnt_q <= 4'd0;
         idle_cnt_q <= '0;
         cmd_stb_q <= 1'b0;
         cmd_word_q <= 34'h0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         value_q <= value_d;
         digit_cnt_q <= digit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         cmd_stb_q <= cmd_stb_d;
         cmd_word_q <= cmd_word_d;
         err_q <= err_d;
      end
   end

   assign o_cmd_stb = cmd_stb_q;
   assign o_cmd_word = cmd_word_q;
   assign o_err = err_q;

`ifdef UART_DEC_ECHO_EN
   logic echo_stb_q, echo_stb_d;
   logic [7:0] echo_char_q, echo_char_d;

   // Bytes dropped while a command is in flight are not echoed.
   always_comb begin
      echo_stb_d = i_rx_stb && (state_q != ISSUE);
      echo_char_d = echo_char_q;
      if (echo_stb_d) begin
         echo_char_d = i_rx_char;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         echo_stb_q <= 1'b0;
         echo_char_q <= 8'h0;
      end else begin
         echo_stb_q <= echo_stb_d;
         echo_char_q <= echo_char_d;
      end
   end

   assign o_echo_stb = echo_stb_q;
   assign o_echo_char = echo_char_q;
`else
   assign o_echo_stb = 1'b0;
   assign o_echo_char = 8'h0;
`endif

endmodule
